spi_clkmux_ctrl: RTL and testbench

Sequencer for the SPI clock-source select. It accepts switch requests from the register/control logic and waits until the SPI core is idle. It then gates the SPI clock, changes the select line driving `spi_clockmux`, lets the new source settle, re-enables the clock and acknowledges. This guarantees the mux select never changes while a transfer is in progress or while the downstream clock is enabled.

---
 rtl/spi_clkmux_pkg.sv | 30 +++
 rtl/spi_clkmux_if.sv | 30 +++
 rtl/spi_clkmux_timer.sv | 34 +++
 rtl/spi_clkmux_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_clkmux_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_clkmux_pkg.sv
// spi_clkmux_pkg
// Shared definitions for the SPI clock-source select sequencer:
//   - state_t        : sequencer states
//   - DEF_*          : default parameter values
//   - cnt_width()    : width of the shared phase/timeout counter
// Optional feature macro used by the design: SPI_CLKMUX_TIMEOUT_EN
package spi_clkmux_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        GATE      = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    localparam int DEF_GATE_CYCLES    = 2;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // $clog2 of the largest count, never narrower than one bit so that
    // an all-ones configuration still yields a legal vector.
    function automatic int cnt_width(input int g, input int s, input int t);
        int m;
        m = g;
        if (s > m) m = s;
        if (t > m) m = t;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/spi_clkmux_if.sv
// spi_clkmux_if
// Bundles the request handshake and SPI-side control of the clock-select
// sequencer.
//   req, req_sel   : switch request pulse and target select
//   spi_busy       : SPI core transfer in progress
//   sel_out        : select line to spi_clockmux
//   clk_en         : SPI clock enable / gate
//   busy, ack      : switch in progress, completion pulse
//   error          : sticky wait-for-idle timeout flag
// Modports: master = register/control side, slave = sequencer.
interface spi_clkmux_if;
    logic req;
    logic req_sel;
    logic spi_busy;
    logic sel_out;
    logic clk_en;
    logic busy;
    logic ack;
    logic error;

    modport master (
        output req, req_sel, spi_busy,
        input  sel_out, clk_en, busy, ack, error
    );

    modport slave (
        input  req, req_sel, spi_busy,
        output sel_out, clk_en, busy, ack, error
    );
endinterface

// File: rtl/spi_clkmux_timer.sv
// spi_clkmux_timer
// Loadable down-counter with a zero flag. One instance is shared by the
// gate, settle and timeout phases since only one is active at a time.
//   pclk, preset : clock, synchronous active-high reset (count -> 0)
//   load         : load load_val (has priority over dec)
//   load_val     : value to load
//   dec          : decrement by one, saturating at zero
//   zero         : count is zero
module spi_clkmux_timer #(
    parameter int W = 4
) (
    input  logic         pclk,
    input  logic         preset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge pclk) begin
        if (preset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_clkmux_ctrl.sv
// spi_clkmux_ctrl
// Sequences a change of the SPI clock-mux select: wait for the SPI core to
// go idle, gate the clock, switch the select, let it settle, re-enable the
// clock and acknowledge. The select never moves while the clock is enabled.
//   pclk   : clock
//   preset : synchronous active-high reset; aborts any switch in progress
//   bus    : spi_clkmux_if.slave (request, SPI status, select/gate outputs)
// Optional feature: define SPI_CLKMUX_TIMEOUT_EN to bound the wait for SPI
// idle to TIMEOUT_CYCLES and raise a sticky error on expiry. Without it the
// wait is unbounded and error is tied low.
module spi_clkmux_ctrl
    import spi_clkmux_pkg::*;
#(
    parameter int   GATE_CYCLES    = DEF_GATE_CYCLES,
    parameter int   SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic SEL_RESET      = 1'b0
) (
    input logic         pclk,
    input logic         preset,
    spi_clkmux_if.slave bus
);

    localparam int CW = cnt_width(GATE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] GATE_LD   = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
`ifdef SPI_CLKMUX_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
`endif

    state_t        state_q, state_n;
    logic          sel_q, sel_n;
    logic          clk_en_q, clk_en_n;
    logic          busy_q, busy_n;
    logic          ack_q, ack_n;
    logic          target_q, target_n;
    logic          tmr_load, tmr_dec, tmr_zero;
    logic [CW-1:0] tmr_val;
`ifdef SPI_CLKMUX_TIMEOUT_EN
    logic          error_q, error_n;
`endif

    spi_clkmux_timer #(.W(CW)) u_timer (
        .pclk     (pclk),
        .preset   (preset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_n  = state_q;
        sel_n    = sel_q;
        clk_en_n = clk_en_q;
        busy_n   = busy_q;
        ack_n    = 1'b0;
        target_n = target_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
`ifdef SPI_CLKMUX_TIMEOUT_EN
        error_n  = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (bus.req_sel != sel_q) begin
                        target_n = bus.req_sel;
                        busy_n   = 1'b1;
                        state_n  = WAIT_IDLE;
`ifdef SPI_CLKMUX_TIMEOUT_EN
                        error_n  = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = TIMEOUT_LD;
`endif
                    end else begin
                        // Already on the requested source: acknowledge only.
                        ack_n = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!bus.spi_busy) begin
                    clk_en_n = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD;
                    state_n  = GATE;
                end
`ifdef SPI_CLKMUX_TIMEOUT_EN
                else if (tmr_zero) begin
                    // Give up: select and gate are left untouched.
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
`endif
            end
            GATE: begin
                if (tmr_zero) begin
                    sel_n    = target_q;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                    state_n  = SETTLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    clk_en_n = 1'b1;
                    ack_n    = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            sel_q    <= SEL_RESET;
            clk_en_q <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            sel_q    <= sel_n;
            clk_en_q <= clk_en_n;
            busy_q   <= busy_n;
            ack_q    <= ack_n;
        end
    end

    // Target is only consumed in GATE, which always follows a capture.
    always_ff @(posedge pclk) begin
        target_q <= target_n;
    end

`ifdef SPI_CLKMUX_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (preset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_n;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.sel_out = sel_q;
    assign bus.clk_en  = clk_en_q;
    assign bus.busy    = busy_q;
    assign bus.ack     = ack_q;

endmodule

// File: tb/tb_spi_clkmux_ctrl.sv
// tb_spi_clkmux_ctrl
// Self-checking bench for spi_clkmux_ctrl: a default-timing instance driven
// from a vector table plus hand-written reset/timeout sequences, and a
// GATE_CYCLES=SETTLE_CYCLES=1 instance for back-to-back requests.
// Honours SPI_CLKMUX_TIMEOUT_EN the same way the design does.
module tb_spi_clkmux_ctrl;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    spi_clkmux_if bus ();
    spi_clkmux_if bus_b ();

    spi_clkmux_ctrl #(
        .GATE_CYCLES    (2),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16),
        .SEL_RESET      (1'b0)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.slave)
    );

    spi_clkmux_ctrl #(
        .GATE_CYCLES    (1),
        .SETTLE_CYCLES  (1),
        .TIMEOUT_CYCLES (16),
        .SEL_RESET      (1'b0)
    ) dut_b (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_b.slave)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int sb_q[$];
    int sb_exp;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each accepted request pushes its expected ack cycle.
    always @(negedge pclk) begin
        if (!preset && bus.ack) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
            end else begin
                sb_exp = sb_q.pop_front();
                check("ack_cycle", cyc, sb_exp);
            end
        end
    end

    // Select may only move on an edge where the clock was already gated.
    logic prev_sel_a = 1'b0, prev_clk_a = 1'b1;
    logic prev_sel_b = 1'b0, prev_clk_b = 1'b1;
    always @(negedge pclk) begin
        if (bus.sel_out !== prev_sel_a) check("sel_change_while_clk_en_a", prev_clk_a, 0);
        if (bus_b.sel_out !== prev_sel_b) check("sel_change_while_clk_en_b", prev_clk_b, 0);
        prev_sel_a <= bus.sel_out;
        prev_clk_a <= bus.clk_en;
        prev_sel_b <= bus_b.sel_out;
        prev_clk_b <= bus_b.clk_en;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time limit, expected $finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic rsel;       // requested select
        int   d;          // cycles spi_busy stays high after the request
        int   extra;      // cycle of an extra (to-be-dropped) req, -1 none
        int   exp_ack;    // expected ack cycle
        int   exp_gate;   // expected first clk_en=0 cycle, -1 no gating
        int   exp_selchg; // expected sel_out change cycle, -1 none
    } vec_t;

    vec_t vecs[6];
    logic cur_sel;
    logic same;
    int   busy_e, clk_e, sel_e, ack_e;

    initial begin
        vecs[0] = '{1'b1, 0,  -1, 8,  2,  4};
        vecs[1] = '{1'b1, 0,  -1, 1,  -1, -1};
        vecs[2] = '{1'b0, 10, 5,  18, 12, 14};
        vecs[3] = '{1'b0, 0,  -1, 1,  -1, -1};
        vecs[4] = '{1'b1, 3,  -1, 11, 5,  7};
        vecs[5] = '{1'b0, 1,  -1, 9,  3,  5};

        bus.req = 1'b0; bus.req_sel = 1'b0; bus.spi_busy = 1'b0;
        bus_b.req = 1'b0; bus_b.req_sel = 1'b0; bus_b.spi_busy = 1'b0;
        cur_sel = 1'b0;

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_sel_out", bus.sel_out, 0);
        check("rst_clk_en", bus.clk_en, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_error", bus.error, 0);
        check("rst_b_sel_out", bus_b.sel_out, 0);
        check("rst_b_clk_en", bus_b.clk_en, 1);
        @(posedge pclk); #1;
        preset = 1'b0;

        // Table-driven switch / same-select / dropped-request vectors
        for (int i = 0; i < 6; i++) begin
            same = (vecs[i].exp_gate < 0);
            @(posedge pclk); #1;
            bus.req = 1'b1; bus.req_sel = vecs[i].rsel; bus.spi_busy = 1'b0;
            sb_q.push_back(cyc + vecs[i].exp_ack);
            for (int k = 1; k <= vecs[i].exp_ack + 2; k++) begin
                @(posedge pclk); #1;
                bus.req = (k == vecs[i].extra);
                bus.req_sel = ~vecs[i].rsel;
                bus.spi_busy = (k <= vecs[i].d);
                @(negedge pclk);
                if (same) begin
                    busy_e = 0; clk_e = 1; sel_e = cur_sel;
                end else begin
                    busy_e = (k < vecs[i].exp_ack) ? 1 : 0;
                    clk_e = (k >= vecs[i].exp_gate && k < vecs[i].exp_ack) ? 0 : 1;
                    sel_e = (k >= vecs[i].exp_selchg) ? vecs[i].rsel : cur_sel;
                end
                ack_e = (k == vecs[i].exp_ack) ? 1 : 0;
                check($sformatf("v%0d_c%0d_busy", i, k), bus.busy, busy_e);
                check($sformatf("v%0d_c%0d_clk_en", i, k), bus.clk_en, clk_e);
                check($sformatf("v%0d_c%0d_sel_out", i, k), bus.sel_out, sel_e);
                check($sformatf("v%0d_c%0d_ack", i, k), bus.ack, ack_e);
                check($sformatf("v%0d_c%0d_error", i, k), bus.error, 0);
            end
            bus.req = 1'b0;
            cur_sel = vecs[i].rsel;
        end

        // Reset in the middle of a 0->1 switch (select already moved)
        @(posedge pclk); #1;
        bus.req = 1'b1; bus.req_sel = 1'b1; bus.spi_busy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge pclk); #1;
            bus.req = 1'b0;
            preset = (k == 5);
            @(negedge pclk);
            if (k == 4) check("abort_pre_sel_out", bus.sel_out, 1);
        end
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        check("abort_sel_out", bus.sel_out, 0);
        check("abort_clk_en", bus.clk_en, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_ack", bus.ack, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge pclk);
            check($sformatf("abort_after_c%0d_ack", k), bus.ack, 0);
            check($sformatf("abort_after_c%0d_busy", k), bus.busy, 0);
        end
        cur_sel = 1'b0;

`ifdef SPI_CLKMUX_TIMEOUT_EN
        // spi_busy stuck high: timeout after 16 busy cycles
        @(posedge pclk); #1;
        bus.req = 1'b1; bus.req_sel = 1'b1; bus.spi_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge pclk); #1;
            bus.req = 1'b0;
            @(negedge pclk);
            check($sformatf("to_c%0d_busy", k), bus.busy, (k <= 16) ? 1 : 0);
            check($sformatf("to_c%0d_error", k), bus.error, (k <= 16) ? 0 : 1);
            check($sformatf("to_c%0d_sel_out", k), bus.sel_out, 0);
            check($sformatf("to_c%0d_clk_en", k), bus.clk_en, 1);
        end
        bus.spi_busy = 1'b0;
        // Next accepted request clears the error and completes normally
        @(posedge pclk); #1;
        bus.req = 1'b1; bus.req_sel = 1'b1;
        sb_q.push_back(cyc + 8);
        for (int k = 1; k <= 10; k++) begin
            @(posedge pclk); #1;
            bus.req = 1'b0;
            @(negedge pclk);
            if (k == 1) check("to_clear_error", bus.error, 0);
        end
        check("to_final_sel_out", bus.sel_out, 1);
`else
        // Without the timeout the wait is unbounded
        @(posedge pclk); #1;
        bus.req = 1'b1; bus.req_sel = 1'b1; bus.spi_busy = 1'b1;
        sb_q.push_back(cyc + 48);
        for (int k = 1; k <= 50; k++) begin
            @(posedge pclk); #1;
            bus.req = 1'b0;
            bus.spi_busy = (k <= 40);
            @(negedge pclk);
            if (k <= 40) begin
                check($sformatf("nto_c%0d_busy", k), bus.busy, 1);
                check($sformatf("nto_c%0d_error", k), bus.error, 0);
                check($sformatf("nto_c%0d_clk_en", k), bus.clk_en, 1);
            end
            if (k == 44) check("nto_sel_out", bus.sel_out, 1);
        end
`endif
        cur_sel = 1'b1;

        // Back-to-back requests on the 1/1 instance
        @(posedge pclk); #1;
        bus_b.req = 1'b1; bus_b.req_sel = 1'b1; bus_b.spi_busy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge pclk); #1;
            bus_b.req = (k == 4);
            bus_b.req_sel = 1'b0;
            @(negedge pclk);
            check($sformatf("b2b_c%0d_ack", k), bus_b.ack, (k == 4 || k == 8) ? 1 : 0);
            check($sformatf("b2b_c%0d_sel_out", k), bus_b.sel_out, (k >= 3 && k < 7) ? 1 : 0);
            check($sformatf("b2b_c%0d_clk_en", k), bus_b.clk_en,
                  ((k >= 2 && k < 4) || (k >= 6 && k < 8)) ? 0 : 1);
            check($sformatf("b2b_c%0d_busy", k), bus_b.busy,
                  ((k >= 1 && k < 4) || (k >= 5 && k < 8)) ? 1 : 0);
        end
        bus_b.req = 1'b0;

        repeat (2) @(negedge pclk);
        check("sb_pending", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
